// File: rtl/trace_replay_pkg.sv
// Shared types and constants for the trace replay sequencer.
package trace_replay_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_OPEN   = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERROR  = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_OPEN  = 2'd1,
        ERR_ORDER = 2'd2
    } err_code_e;

    localparam int RETIRED_W = 32;
    localparam int BLANK_W   = 16;
    localparam int ORDER_W   = 64;

endpackage

// File: rtl/trace_replay_fifo.sv
// Synchronous record FIFO; supports push and pop in the same cycle, including when full.
module trace_replay_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] wdata_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q;
    logic [AW:0]  wr_ptr_d;
    logic [AW:0]  rd_ptr_q;
    logic [AW:0]  rd_ptr_d;
    logic         do_push_s;
    logic         do_pop_s;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop_s  = pop_i && !empty_o;
    assign do_push_s = push_i && (!full_o || do_pop_s);
    assign rdata_o   = mem_q[rd_ptr_q[AW-1:0]];

    // Next-state pointer arithmetic.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Pointer registers; reset flushes the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/trace_replay_ctrl.sv
// Walks a list of trace files, order-checks parsed records and replays them as RVVI retirement strobes.
module trace_replay_ctrl
    import trace_replay_pkg::*;
#(
    parameter int REC_W  = 256,
    parameter int DEPTH  = 4,
    parameter int FIDX_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [FIDX_W-1:0] num_files,
    output logic              file_req,
    output logic [FIDX_W-1:0] file_idx,
    input  logic              file_ack,
    input  logic              file_err,
    input  logic              rec_valid,
    output logic              rec_ready,
    input  logic              rec_blank,
    input  logic              rec_eof,
    input  logic [63:0]       rec_order,
    input  logic [REC_W-1:0]  rec_data,
    input  logic              hold,
    output logic              rvvi_valid,
    output logic [63:0]       rvvi_order,
    output logic [REC_W-1:0]  rvvi_data,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [31:0]       retired_cnt,
    output logic [15:0]       blank_cnt
);

    localparam int FW = ORDER_W + REC_W;

    state_e               state_q, state_d;
    err_code_e            err_code_q, err_code_d;
    logic [FIDX_W-1:0]    file_idx_q, file_idx_d;
    logic [FIDX_W-1:0]    num_files_q, num_files_d;
    logic [ORDER_W-1:0]   last_order_q, last_order_d;
    logic                 first_q, first_d;
    logic [RETIRED_W-1:0] retired_cnt_q, retired_cnt_d;
    logic [BLANK_W-1:0]   blank_cnt_q, blank_cnt_d;
    logic                 file_req_q, done_q, error_q;
    logic                 rvvi_valid_q;
    logic [ORDER_W-1:0]   rvvi_order_q;
    logic [REC_W-1:0]     rvvi_data_q;

    logic                 clr_cnt_s;
    logic                 accept_s, is_eof_s, is_blank_s, is_data_s, order_bad_s;
    logic                 last_file_s;
    logic                 fifo_push_s, fifo_pop_s, fifo_full_s, fifo_empty_s;
    logic [FW-1:0]        fifo_wdata_s, fifo_rdata_s;

    assign rec_ready    = (state_q == ST_STREAM) && !fifo_full_s;
    assign accept_s     = rec_valid && rec_ready;
    assign is_eof_s     = accept_s && rec_eof;
    assign is_blank_s   = accept_s && rec_blank && !rec_eof;
    assign is_data_s    = accept_s && !rec_blank && !rec_eof;
    // The first record after a file opens is exempt from the ordering check.
    assign order_bad_s  = is_data_s && !first_q && (rec_order <= last_order_q);
    assign fifo_push_s  = is_data_s && !order_bad_s;
    assign fifo_pop_s   = !fifo_empty_s && !hold && (state_q != ST_ERROR);
    assign fifo_wdata_s = {rec_order, rec_data};
    assign last_file_s  = ({1'b0, file_idx_q} + (FIDX_W+1)'(1)) == {1'b0, num_files_q};

    trace_replay_fifo #(
        .DEPTH (DEPTH),
        .W     (FW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset_n),
        .push_i  (fifo_push_s),
        .pop_i   (fifo_pop_s),
        .wdata_i (fifo_wdata_s),
        .rdata_o (fifo_rdata_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    // Sequencer next-state logic.
    always_comb begin
        state_d      = state_q;
        err_code_d   = err_code_q;
        file_idx_d   = file_idx_q;
        num_files_d  = num_files_q;
        last_order_d = last_order_q;
        first_d      = first_q;
        clr_cnt_s    = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    clr_cnt_s   = 1'b1;
                    num_files_d = num_files;
                    file_idx_d  = '0;
                    if (num_files == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_OPEN;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_OPEN: begin
                if (file_err) begin
                    state_d    = ST_ERROR;
                    err_code_d = ERR_OPEN;
                end else if (file_ack) begin
                    state_d = ST_STREAM;
                    first_d = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            ST_STREAM: begin
                if (is_eof_s) begin
                    state_d = ST_DRAIN;
                end else if (order_bad_s) begin
                    state_d    = ST_ERROR;
                    err_code_d = ERR_ORDER;
                end else if (fifo_push_s) begin
                    last_order_d = rec_order;
                    first_d      = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty_s && !rvvi_valid_q) begin
                    if (last_file_s) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d    = ST_OPEN;
                        file_idx_d = file_idx_q + FIDX_W'(1);
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Saturating statistics counters.
    always_comb begin
        retired_cnt_d = retired_cnt_q;
        blank_cnt_d   = blank_cnt_q;
        if (clr_cnt_s) begin
            retired_cnt_d = '0;
            blank_cnt_d   = '0;
        end else begin
            if (fifo_pop_s && (retired_cnt_q != '1)) begin
                retired_cnt_d = retired_cnt_q + RETIRED_W'(1);
            end else begin
                retired_cnt_d = retired_cnt_q;
            end
            if (is_blank_s && (blank_cnt_q != '1)) begin
                blank_cnt_d = blank_cnt_q + BLANK_W'(1);
            end else begin
                blank_cnt_d = blank_cnt_q;
            end
        end
    end

    // State, status and retirement output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            err_code_q    <= ERR_NONE;
            file_idx_q    <= '0;
            num_files_q   <= '0;
            last_order_q  <= '0;
            first_q       <= 1'b0;
            retired_cnt_q <= '0;
            blank_cnt_q   <= '0;
            file_req_q    <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            rvvi_valid_q  <= 1'b0;
            rvvi_order_q  <= '0;
            rvvi_data_q   <= '0;
        end else begin
            state_q       <= state_d;
            err_code_q    <= err_code_d;
            file_idx_q    <= file_idx_d;
            num_files_q   <= num_files_d;
            last_order_q  <= last_order_d;
            first_q       <= first_d;
            retired_cnt_q <= retired_cnt_d;
            blank_cnt_q   <= blank_cnt_d;
            file_req_q    <= (state_d == ST_OPEN);
            done_q        <= (state_d == ST_DONE);
            error_q       <= (state_d == ST_ERROR);
            rvvi_valid_q  <= fifo_pop_s;
            rvvi_order_q  <= fifo_pop_s ? fifo_rdata_s[FW-1 -: ORDER_W] : '0;
            rvvi_data_q   <= fifo_pop_s ? fifo_rdata_s[REC_W-1:0] : '0;
        end
    end

    assign file_req    = file_req_q;
    assign file_idx    = file_idx_q;
    assign rvvi_valid  = rvvi_valid_q;
    assign rvvi_order  = rvvi_order_q;
    assign rvvi_data   = rvvi_data_q;
    assign done        = done_q;
    assign error       = error_q;
    assign err_code    = err_code_q;
    assign retired_cnt = retired_cnt_q;
    assign blank_cnt   = blank_cnt_q;

endmodule

// File: tb/tb_trace_replay_ctrl.sv
// Directed self-checking bench for trace_replay_ctrl.
module tb_trace_replay_ctrl;

    localparam int REC_W  = 256;
    localparam int DEPTH  = 4;
    localparam int FIDX_W = 8;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic [FIDX_W-1:0] num_files;
    logic              file_req;
    logic [FIDX_W-1:0] file_idx;
    logic              file_ack;
    logic              file_err;
    logic              rec_valid;
    logic              rec_ready;
    logic              rec_blank;
    logic              rec_eof;
    logic [63:0]       rec_order;
    logic [REC_W-1:0]  rec_data;
    logic              hold;
    logic              rvvi_valid;
    logic [63:0]       rvvi_order;
    logic [REC_W-1:0]  rvvi_data;
    logic              done;
    logic              error;
    logic [1:0]        err_code;
    logic [31:0]       retired_cnt;
    logic [15:0]       blank_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int data_bad = 0;
    int idle_bad = 0;
    logic [63:0] seen_q [$];
    int          seen_cyc [$];

    always #5 clk = ~clk;

    trace_replay_ctrl #(.REC_W(REC_W), .DEPTH(DEPTH), .FIDX_W(FIDX_W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .num_files(num_files),
        .file_req(file_req), .file_idx(file_idx), .file_ack(file_ack), .file_err(file_err),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_blank(rec_blank), .rec_eof(rec_eof),
        .rec_order(rec_order), .rec_data(rec_data), .hold(hold),
        .rvvi_valid(rvvi_valid), .rvvi_order(rvvi_order), .rvvi_data(rvvi_data),
        .done(done), .error(error), .err_code(err_code),
        .retired_cnt(retired_cnt), .blank_cnt(blank_cnt)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Record every retirement; payload is built as four copies of the ORDER.
    always @(negedge clk) begin
        if (rvvi_valid === 1'b1) begin
            seen_q.push_back(rvvi_order);
            seen_cyc.push_back(cyc);
            if (rvvi_data !== {4{rvvi_order}}) data_bad++;
        end else if (rvvi_order !== 64'd0 || rvvi_data !== {REC_W{1'b0}}) begin
            idle_bad++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_seen();
        seen_q.delete();
        seen_cyc.delete();
    endtask

    task automatic do_reset();
        reset_n = 1'b0; start = 1'b0; num_files = '0; file_ack = 1'b0; file_err = 1'b0;
        rec_valid = 1'b0; rec_blank = 1'b0; rec_eof = 1'b0; rec_order = 64'd0;
        rec_data = '0; hold = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        tick();
        clear_seen();
    endtask

    task automatic do_start(input logic [FIDX_W-1:0] nf);
        num_files = nf; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_req(output bit ok);
        for (int n = 0; n < 50 && file_req !== 1'b1; n++) tick();
        ok = (file_req === 1'b1);
    endtask

    task automatic pulse_open(input logic ack, input logic err);
        file_ack = ack; file_err = err;
        tick();
        file_ack = 1'b0; file_err = 1'b0;
    endtask

    task automatic send_rec(input logic blank, input logic eof, input logic [63:0] ord, output bit ok);
        ok = 1'b0;
        rec_valid = 1'b1; rec_blank = blank; rec_eof = eof; rec_order = ord;
        rec_data = {4{ord}};
        for (int n = 0; n < 40 && !ok; n++) begin
            if (rec_ready === 1'b1) ok = 1'b1;
            tick();
        end
        rec_valid = 1'b0; rec_blank = 1'b0; rec_eof = 1'b0; rec_order = 64'd0; rec_data = '0;
    endtask

    task automatic wait_done(output bit ok);
        for (int n = 0; n < 60 && done !== 1'b1; n++) tick();
        ok = (done === 1'b1);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; num_files = '0; file_ack = 1'b0; file_err = 1'b0;
        rec_valid = 1'b0; rec_blank = 1'b0; rec_eof = 1'b0; rec_order = 64'd0;
        rec_data = '0; hold = 1'b0;
        tick(); tick();
        checks++;
        if ({file_req, file_idx, rec_ready, rvvi_valid, done, error, err_code} !== 15'd0) begin
            errors++;
            $display("FAIL reset_ctrl: got req=%0b idx=%0d rdy=%0b v=%0b done=%0b err=%0b code=%0d required all 0",
                     file_req, file_idx, rec_ready, rvvi_valid, done, error, err_code);
        end
        checks++;
        if (rvvi_order !== 64'd0 || rvvi_data !== {REC_W{1'b0}} || retired_cnt !== 32'd0 || blank_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_data: got order=%0h ret=%0d blank=%0d required 0", rvvi_order, retired_cnt, blank_cnt);
        end
        reset_n = 1'b1;
        tick();
        clear_seen();
    endtask

    task automatic test_two_files();
        bit ok;
        logic [63:0] exp [6] = '{64'd1, 64'd2, 64'd3, 64'd1, 64'd2, 64'd3};
        do_start(8'd2);
        for (int f = 0; f < 2; f++) begin
            wait_req(ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL two_files_req: file_req=%0b required 1", file_req); end
            checks++;
            if (file_idx !== f[FIDX_W-1:0]) begin
                errors++; $display("FAIL two_files_idx: got %0d required %0d", file_idx, f);
            end
            pulse_open(1'b1, 1'b0);
            for (int r = 1; r <= 3; r++) send_rec(1'b0, 1'b0, 64'(r), ok);
            send_rec(1'b0, 1'b1, 64'd0, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL two_files_eof: eof accepted=%0b required 1", ok); end
        end
        wait_done(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL two_files_done: done=%0b required 1", done); end
        checks++;
        if (seen_q.size() != 6) begin
            errors++; $display("FAIL two_files_count: got %0d strobes required 6", seen_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (seen_q[i] !== exp[i]) begin
                    errors++; $display("FAIL two_files_order[%0d]: got %0d required %0d", i, seen_q[i], exp[i]);
                end
            end
        end
        checks++;
        if (retired_cnt !== 32'd6) begin
            errors++; $display("FAIL two_files_retired: got %0d required 6", retired_cnt);
        end
        checks++;
        if (data_bad != 0) begin errors++; $display("FAIL two_files_payload: got %0d bad payloads required 0", data_bad); end
    endtask

    task automatic test_blanks();
        bit ok;
        clear_seen();
        do_start(8'd1);
        checks++;
        if (done !== 1'b0 || retired_cnt !== 32'd0 || blank_cnt !== 16'd0) begin
            errors++; $display("FAIL blanks_clear: got done=%0b ret=%0d blank=%0d required 0 0 0", done, retired_cnt, blank_cnt);
        end
        wait_req(ok);
        pulse_open(1'b1, 1'b0);
        send_rec(1'b1, 1'b0, 64'd99, ok);
        send_rec(1'b0, 1'b0, 64'd5, ok);
        send_rec(1'b1, 1'b0, 64'd99, ok);
        send_rec(1'b0, 1'b0, 64'd6, ok);
        send_rec(1'b1, 1'b1, 64'd0, ok);
        wait_done(ok);
        checks++;
        if (!ok || error !== 1'b0) begin errors++; $display("FAIL blanks_done: done=%0b error=%0b required 1 0", done, error); end
        checks++;
        if (seen_q.size() != 2 || seen_q[0] !== 64'd5 || seen_q[1] !== 64'd6) begin
            errors++; $display("FAIL blanks_orders: got %0d strobes required 2 (5,6)", seen_q.size());
        end
        checks++;
        if (blank_cnt !== 16'd2) begin errors++; $display("FAIL blanks_cnt: got %0d required 2", blank_cnt); end
        checks++;
        if (idle_bad != 0) begin errors++; $display("FAIL blanks_idle_zero: got %0d nonzero idle cycles required 0", idle_bad); end
    endtask

    task automatic test_order_violation();
        bit ok;
        int rdy_seen;
        do_reset();
        do_start(8'd1);
        wait_req(ok);
        pulse_open(1'b1, 1'b0);
        send_rec(1'b0, 1'b0, 64'd10, ok);
        send_rec(1'b0, 1'b0, 64'd11, ok);
        send_rec(1'b0, 1'b0, 64'd11, ok);
        rdy_seen = 0;
        rec_valid = 1'b1; rec_order = 64'd12; rec_data = {4{64'd12}};
        for (int n = 0; n < 5; n++) begin
            if (rec_ready !== 1'b0) rdy_seen++;
            tick();
        end
        rec_valid = 1'b0;
        checks++;
        if (error !== 1'b1 || err_code !== 2'd2) begin
            errors++; $display("FAIL order_err: got error=%0b code=%0d required 1 2", error, err_code);
        end
        checks++;
        if (rdy_seen != 0) begin errors++; $display("FAIL order_ready: got %0d ready cycles required 0", rdy_seen); end
        checks++;
        if (seen_q.size() != 2 || seen_q[0] !== 64'd10 || seen_q[1] !== 64'd11) begin
            errors++; $display("FAIL order_strobes: got %0d strobes required 2 (10,11)", seen_q.size());
        end
        do_start(8'd1);
        tick();
        checks++;
        if (error !== 1'b1 || file_req !== 1'b0 || retired_cnt !== 32'd2) begin
            errors++; $display("FAIL order_terminal: got error=%0b req=%0b ret=%0d required 1 0 2", error, file_req, retired_cnt);
        end
    endtask

    task automatic test_open_fail();
        bit ok;
        do_reset();
        do_start(8'd3);
        wait_req(ok);
        pulse_open(1'b1, 1'b1);
        tick(); tick();
        checks++;
        if (error !== 1'b1 || err_code !== 2'd1 || file_req !== 1'b0) begin
            errors++; $display("FAIL open_fail: got error=%0b code=%0d req=%0b required 1 1 0", error, err_code, file_req);
        end
        checks++;
        if (seen_q.size() != 0) begin errors++; $display("FAIL open_fail_strobes: got %0d required 0", seen_q.size()); end
    endtask

    task automatic test_hold();
        bit ok;
        int rdy_seen;
        do_reset();
        do_start(8'd1);
        wait_req(ok);
        hold = 1'b1;
        pulse_open(1'b1, 1'b0);
        for (int r = 1; r <= 4; r++) begin
            send_rec(1'b0, 1'b0, 64'(r), ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL hold_accept%0d: accepted=%0b required 1", r, ok); end
        end
        rdy_seen = 0;
        rec_valid = 1'b1; rec_order = 64'd5; rec_data = {4{64'd5}};
        for (int n = 0; n < 3; n++) begin
            if (rec_ready !== 1'b0) rdy_seen++;
            tick();
        end
        checks++;
        if (rdy_seen != 0 || seen_q.size() != 0) begin
            errors++; $display("FAIL hold_full: got %0d ready cycles %0d strobes required 0 0", rdy_seen, seen_q.size());
        end
        hold = 1'b0;
        send_rec(1'b0, 1'b0, 64'd5, ok);
        send_rec(1'b0, 1'b1, 64'd0, ok);
        wait_done(ok);
        checks++;
        if (seen_q.size() != 5) begin
            errors++; $display("FAIL hold_count: got %0d strobes required 5", seen_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (seen_q[i] !== 64'(i + 1) || seen_cyc[i] != seen_cyc[0] + i) begin
                    errors++; $display("FAIL hold_seq[%0d]: got order %0d cycle +%0d required %0d +%0d",
                                       i, seen_q[i], seen_cyc[i] - seen_cyc[0], i + 1, i);
                end
            end
        end
    endtask

    task automatic test_reset_mid_stream();
        bit ok;
        do_reset();
        do_start(8'd1);
        wait_req(ok);
        hold = 1'b1;
        pulse_open(1'b1, 1'b0);
        send_rec(1'b0, 1'b0, 64'd10, ok);
        send_rec(1'b0, 1'b0, 64'd20, ok);
        send_rec(1'b0, 1'b0, 64'd30, ok);
        hold = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({file_req, file_idx, rec_ready, rvvi_valid, done, error, err_code} !== 15'd0 ||
            rvvi_order !== 64'd0 || retired_cnt !== 32'd0) begin
            errors++; $display("FAIL midreset_zero: got req=%0b rdy=%0b v=%0b ret=%0d required all 0",
                               file_req, rec_ready, rvvi_valid, retired_cnt);
        end
        tick();
        reset_n = 1'b1;
        tick();
        clear_seen();
        do_start(8'd1);
        wait_req(ok);
        checks++;
        if (!ok || file_idx !== 8'd0) begin errors++; $display("FAIL midreset_idx: got req=%0b idx=%0d required 1 0", file_req, file_idx); end
        pulse_open(1'b1, 1'b0);
        for (int n = 0; n < 5; n++) tick();
        checks++;
        if (seen_q.size() != 0) begin errors++; $display("FAIL midreset_stale: got %0d strobes required 0", seen_q.size()); end
        send_rec(1'b0, 1'b0, 64'd7, ok);
        send_rec(1'b0, 1'b1, 64'd0, ok);
        wait_done(ok);
        checks++;
        if (seen_q.size() != 1 || seen_q[0] !== 64'd7 || retired_cnt !== 32'd1) begin
            errors++; $display("FAIL midreset_replay: got %0d strobes ret=%0d required 1 strobe (7) ret=1", seen_q.size(), retired_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_two_files();
        test_blanks();
        test_order_violation();
        test_open_fail();
        test_hold();
        test_reset_mid_stream();
        checks++;
        if (data_bad != 0 || idle_bad != 0) begin
            errors++; $display("FAIL payload_overall: got %0d bad payloads %0d nonzero idle required 0 0", data_bad, idle_bad);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
